// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: control FSM vs. mult/div unit.
// Fixed priority for ctrl with anti-starvation for md, one registered
// writeback stage giving one write per cycle.
module wb_port_arbiter #(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ctrl_req,
   input  logic [2:0]       ctrl_sel,
   output logic             ctrl_gnt,
   input  logic             md_req,
   input  logic [2:0]       md_sel,
   output logic             md_gnt,
   input  logic             rf_hold,
   input  logic             flush,
   output logic [2:0]       wd_sel,
   output logic             reg_write,
   output logic             err_sel,
   output logic [CNT_W-1:0] wr_count
);

   localparam int unsigned SEL_W    = 3;
   localparam int unsigned STARVE_W = 4;
   localparam int unsigned SEL_MAX  = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [SEL_W-1:0]    wd_sel_q, wd_sel_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [STARVE_W-1:0] starve_q, starve_d;

   logic                accept;
   logic [SEL_W-1:0]    acc_sel;
   logic                acc_illegal;

   // Grant decision: blocked by hold/flush/reset, md forced after STARVE_MAX losses
   always_comb begin
      ctrl_gnt = 1'b0;
      md_gnt   = 1'b0;
      if (reset && !rf_hold && !flush) begin
         if (ctrl_req && md_req) begin
            if (starve_q == STARVE_W'(STARVE_MAX)) begin
               md_gnt = 1'b1;
            end else begin
               ctrl_gnt = 1'b1;
            end
         end else begin
            ctrl_gnt = ctrl_req;
            md_gnt   = md_req;
         end
      end
   end

   // Accepted transfer and its legality
   always_comb begin
      accept      = ctrl_gnt | md_gnt;
      acc_sel     = ctrl_gnt ? ctrl_sel : md_sel;
      acc_illegal = (acc_sel > SEL_W'(SEL_MAX));
   end

   // Next-state: writeback FSM, selector latch, error flag, counters
   always_comb begin
      state_d  = IDLE;
      wd_sel_d = wd_sel_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      starve_d = starve_q;

      case (state_q)
         IDLE:    cnt_d = cnt_q;
         WRITE:   cnt_d = cnt_q + CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase

      if (accept) begin
         if (acc_illegal) begin
            err_d = 1'b1;
         end else begin
            state_d  = WRITE;
            wd_sel_d = acc_sel;
         end
      end

      if (md_req && !md_gnt) begin
         if (starve_q < STARVE_W'(STARVE_MAX)) begin
            starve_d = starve_q + STARVE_W'(1);
         end
      end else begin
         starve_d = '0;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         wd_sel_q <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         wd_sel_q <= wd_sel_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
      end
   end

   // Outputs come straight from registers
   always_comb begin
      reg_write = (state_q == WRITE);
      wd_sel    = wd_sel_q;
      err_sel   = err_q;
      wr_count  = cnt_q;
   end

endmodule
